// File: rtl/stg_wb_skid_if.sv
// stg_wb_skid_if: bus between the writeback skid stage and its environment.
//   Upstream entry : iw_valid/ow_ready handshake, iw_pc, iw_instr, iw_result, iw_wr_en, iw_rd, iw_flush
//   Output entry   : ow_valid/iw_ready handshake, ow_pc, ow_instr
//   Register file  : ow_rf_we, ow_rf_waddr, ow_rf_wdata
//   Retire counter : ow_retire_cnt (only with STG_WB_RETIRE_CNT_EN)
//   Modports: slave = stage side, master = environment side.
interface stg_wb_skid_if #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 24,
   parameter int REG_IDX_W = 4
`ifdef STG_WB_RETIRE_CNT_EN
   ,
   parameter int CNT_W     = 32
`endif
);
   logic                 iw_valid;
   logic                 ow_ready;
   logic [ADDR_W-1:0]    iw_pc;
   logic [DATA_W-1:0]    iw_instr;
   logic [DATA_W-1:0]    iw_result;
   logic                 iw_wr_en;
   logic [REG_IDX_W-1:0] iw_rd;
   logic                 iw_flush;
   logic                 ow_valid;
   logic                 iw_ready;
   logic [ADDR_W-1:0]    ow_pc;
   logic [DATA_W-1:0]    ow_instr;
   logic                 ow_rf_we;
   logic [REG_IDX_W-1:0] ow_rf_waddr;
   logic [DATA_W-1:0]    ow_rf_wdata;
`ifdef STG_WB_RETIRE_CNT_EN
   logic [CNT_W-1:0]     ow_retire_cnt;
   modport slave (
      input  iw_valid, iw_pc, iw_instr, iw_result, iw_wr_en, iw_rd, iw_flush, iw_ready,
      output ow_ready, ow_valid, ow_pc, ow_instr, ow_rf_we, ow_rf_waddr, ow_rf_wdata, ow_retire_cnt
   );
   modport master (
      output iw_valid, iw_pc, iw_instr, iw_result, iw_wr_en, iw_rd, iw_flush, iw_ready,
      input  ow_ready, ow_valid, ow_pc, ow_instr, ow_rf_we, ow_rf_waddr, ow_rf_wdata, ow_retire_cnt
   );
`else
   modport slave (
      input  iw_valid, iw_pc, iw_instr, iw_result, iw_wr_en, iw_rd, iw_flush, iw_ready,
      output ow_ready, ow_valid, ow_pc, ow_instr, ow_rf_we, ow_rf_waddr, ow_rf_wdata
   );
   modport master (
      output iw_valid, iw_pc, iw_instr, iw_result, iw_wr_en, iw_rd, iw_flush, iw_ready,
      input  ow_ready, ow_valid, ow_pc, ow_instr, ow_rf_we, ow_rf_waddr, ow_rf_wdata
   );
`endif
endinterface

// File: rtl/stg_wb_skid.sv
// stg_wb_skid: writeback pipeline stage with a 2-entry skid buffer and register-file write port.
//   iw_clk : clock, rising edge
//   iw_rst : asynchronous active-high reset
//   bus    : stg_wb_skid_if.slave (upstream entry, output entry, register-file write, retire count)
//   Optional retire counter enabled by macro STG_WB_RETIRE_CNT_EN.
module stg_wb_skid #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 24,
   parameter int REG_IDX_W = 4,
   parameter int ZERO_REG  = 1
`ifdef STG_WB_RETIRE_CNT_EN
   ,
   parameter int CNT_W     = 32
`endif
) (
   input logic          iw_clk,
   input logic          iw_rst,
   stg_wb_skid_if.slave bus
);
   typedef struct packed {
      logic [ADDR_W-1:0]    pc;
      logic [DATA_W-1:0]    instr;
      logic [DATA_W-1:0]    result;
      logic                 wr_en;
      logic [REG_IDX_W-1:0] rd;
   } entry_t;
   entry_t in_e, m_q, m_d, s_q, s_d;
   logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   logic   ready, accept, drain, rd_zero;
   assign in_e   = {bus.iw_pc, bus.iw_instr, bus.iw_result, bus.iw_wr_en, bus.iw_rd};
   // Readiness depends only on skid occupancy, so iw_ready never reaches ow_ready.
   assign ready  = !s_valid_q && !iw_rst;
   assign accept = bus.iw_valid && ready && !bus.iw_flush;
   assign drain  = m_valid_q && bus.iw_ready;
   always_comb begin
      m_d       = m_q;
      s_d       = s_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      if (bus.iw_flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!m_valid_q || drain) begin
         // Main slot frees up: the older skid entry moves first to keep FIFO order.
         m_valid_d = s_valid_q || accept;
         m_d       = s_valid_q ? s_q : accept ? in_e : m_q;
         s_valid_d = s_valid_q && accept;
         s_d       = (s_valid_q && accept) ? in_e : s_q;
      end else if (accept) begin
         s_valid_d = 1'b1;
         s_d       = in_e;
      end
   end
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         m_q       <= '0;
         s_q       <= '0;
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
      end else begin
         m_q       <= m_d;
         s_q       <= s_d;
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
      end
   end
   assign rd_zero         = (ZERO_REG != 0) && (m_q.rd == '0);
   assign bus.ow_ready    = ready;
   assign bus.ow_valid    = m_valid_q;
   assign bus.ow_pc       = m_q.pc;
   assign bus.ow_instr    = m_q.instr;
   assign bus.ow_rf_we    = drain && m_q.wr_en && !rd_zero;
   assign bus.ow_rf_waddr = m_q.rd;
   assign bus.ow_rf_wdata = m_q.result;
`ifdef STG_WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + CNT_W'(drain);
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign bus.ow_retire_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_stg_wb_skid.sv
// tb_stg_wb_skid: table-driven directed bench for stg_wb_skid (ZERO_REG=1 and ZERO_REG=0 instances).
module tb_stg_wb_skid;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   always #5 clk = ~clk;
`ifdef STG_WB_RETIRE_CNT_EN
   stg_wb_skid_if #(.CNT_W(4)) b0 ();
   stg_wb_skid_if #(.CNT_W(4)) b1 ();
   stg_wb_skid #(.ZERO_REG(1), .CNT_W(4)) dut0 (.iw_clk(clk), .iw_rst(rst), .bus(b0));
   stg_wb_skid #(.ZERO_REG(0), .CNT_W(4)) dut1 (.iw_clk(clk), .iw_rst(rst), .bus(b1));
`else
   stg_wb_skid_if b0 ();
   stg_wb_skid_if b1 ();
   stg_wb_skid #(.ZERO_REG(1)) dut0 (.iw_clk(clk), .iw_rst(rst), .bus(b0));
   stg_wb_skid #(.ZERO_REG(0)) dut1 (.iw_clk(clk), .iw_rst(rst), .bus(b1));
`endif
   assign b1.iw_valid  = b0.iw_valid;
   assign b1.iw_pc     = b0.iw_pc;
   assign b1.iw_instr  = b0.iw_instr;
   assign b1.iw_result = b0.iw_result;
   assign b1.iw_wr_en  = b0.iw_wr_en;
   assign b1.iw_rd     = b0.iw_rd;
   assign b1.iw_flush  = b0.iw_flush;
   assign b1.iw_ready  = b0.iw_ready;
   typedef struct {
      logic        v;
      logic [23:0] pc;
      logic        we;
      logic [3:0]  rd;
      logic        fl;
      logic        rdy;
      logic        ev;
      logic        er;
      logic [23:0] epc;
      logic        ewe;
      logic        ewe1;
      logic [3:0]  ewa;
   } vec_t;
   vec_t tv[21];
   function automatic vec_t mk(input logic v, input logic [23:0] pc, input logic we, input logic [3:0] rd,
                               input logic fl, input logic rdy, input logic ev, input logic er,
                               input logic [23:0] epc, input logic ewe, input logic ewe1, input logic [3:0] ewa);
      vec_t t;
      t.v = v; t.pc = pc; t.we = we; t.rd = rd; t.fl = fl; t.rdy = rdy;
      t.ev = ev; t.er = er; t.epc = epc; t.ewe = ewe; t.ewe1 = ewe1; t.ewa = ewa;
      return t;
   endfunction
   function automatic logic [23:0] ins_of(input logic [23:0] pc);
      return 24'h123446 + pc;
   endfunction
   function automatic logic [23:0] res_of(input logic [23:0] pc);
      return 24'hABCDDF + pc;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic drive(input logic v, input logic [23:0] pc, input logic we, input logic [3:0] rd,
                        input logic fl, input logic rdy);
      b0.iw_valid  = v;
      b0.iw_pc     = pc;
      b0.iw_instr  = ins_of(pc);
      b0.iw_result = res_of(pc);
      b0.iw_wr_en  = we;
      b0.iw_rd     = rd;
      b0.iw_flush  = fl;
      b0.iw_ready  = rdy;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      tv[0]  = mk(1, 24'h10, 1, 3, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[1]  = mk(0, 24'h00, 0, 0, 0, 1,  1, 1, 24'h10, 1, 1, 3);
      tv[2]  = mk(0, 24'h00, 0, 0, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[3]  = mk(1, 24'h10, 1, 5, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[4]  = mk(1, 24'h11, 1, 5, 0, 0,  1, 1, 24'h10, 0, 0, 5);
      tv[5]  = mk(1, 24'h12, 1, 5, 0, 0,  1, 0, 24'h10, 0, 0, 5);
      tv[6]  = mk(1, 24'h12, 1, 5, 0, 1,  1, 0, 24'h10, 1, 1, 5);
      tv[7]  = mk(1, 24'h12, 1, 5, 0, 1,  1, 1, 24'h11, 1, 1, 5);
      tv[8]  = mk(1, 24'h13, 1, 5, 0, 1,  1, 1, 24'h12, 1, 1, 5);
      tv[9]  = mk(0, 24'h00, 0, 0, 0, 1,  1, 1, 24'h13, 1, 1, 5);
      tv[10] = mk(0, 24'h00, 0, 0, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[11] = mk(1, 24'h30, 1, 0, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[12] = mk(0, 24'h00, 0, 0, 0, 1,  1, 1, 24'h30, 0, 1, 0);
      tv[13] = mk(0, 24'h00, 0, 0, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[14] = mk(1, 24'h40, 1, 2, 0, 0,  0, 1, 24'h00, 0, 0, 0);
      tv[15] = mk(1, 24'h41, 1, 2, 0, 0,  1, 1, 24'h40, 0, 0, 2);
      tv[16] = mk(1, 24'h42, 1, 2, 1, 0,  1, 0, 24'h40, 0, 0, 2);
      tv[17] = mk(0, 24'h00, 0, 0, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[18] = mk(1, 24'h20, 1, 2, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      tv[19] = mk(0, 24'h00, 0, 0, 0, 1,  1, 1, 24'h20, 1, 1, 2);
      tv[20] = mk(0, 24'h00, 0, 0, 0, 1,  0, 1, 24'h00, 0, 0, 0);
      drive(0, 24'h0, 0, 0, 0, 0);
      #1;
      chk("rst valid", b0.ow_valid, 0);
      chk("rst ready", b0.ow_ready, 0);
      chk("rst we", b0.ow_rf_we, 0);
      chk("rst pc", b0.ow_pc, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-rst ready", b0.ow_ready, 1);
      chk("post-rst valid", b0.ow_valid, 0);
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         drive(tv[i].v, tv[i].pc, tv[i].we, tv[i].rd, tv[i].fl, tv[i].rdy);
         #1;
         chk($sformatf("row%0d valid", i), b0.ow_valid, tv[i].ev);
         chk($sformatf("row%0d ready", i), b0.ow_ready, tv[i].er);
         chk($sformatf("row%0d rf_we", i), b0.ow_rf_we, tv[i].ewe);
         chk($sformatf("row%0d rf_we zr0", i), b1.ow_rf_we, tv[i].ewe1);
         if (tv[i].ev) begin
            chk($sformatf("row%0d pc", i), b0.ow_pc, tv[i].epc);
            chk($sformatf("row%0d instr", i), b0.ow_instr, ins_of(tv[i].epc));
            chk($sformatf("row%0d waddr", i), b0.ow_rf_waddr, tv[i].ewa);
            chk($sformatf("row%0d wdata", i), b0.ow_rf_wdata, res_of(tv[i].epc));
            chk($sformatf("row%0d waddr zr0", i), b1.ow_rf_waddr, tv[i].ewa);
         end
      end
      // Asynchronous reset while both slots hold entries.
      @(negedge clk);
      drive(1, 24'h50, 1, 6, 0, 0);
      @(negedge clk);
      drive(1, 24'h51, 1, 6, 0, 0);
      @(negedge clk);
      drive(0, 24'h0, 0, 0, 0, 0);
      #1;
      chk("full valid", b0.ow_valid, 1);
      chk("full ready", b0.ow_ready, 0);
      chk("full pc", b0.ow_pc, 24'h50);
      #1;
      rst = 1'b1;
      #1;
      chk("arst valid", b0.ow_valid, 0);
      chk("arst ready", b0.ow_ready, 0);
      chk("arst pc", b0.ow_pc, 0);
      chk("arst instr", b0.ow_instr, 0);
      chk("arst waddr", b0.ow_rf_waddr, 0);
      chk("arst wdata", b0.ow_rf_wdata, 0);
      chk("arst we", b0.ow_rf_we, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b0.iw_ready = 1'b1;
      #1;
      chk("arst rel valid", b0.ow_valid, 0);
      chk("arst rel ready", b0.ow_ready, 1);
      @(negedge clk);
      #1;
      chk("arst stale valid", b0.ow_valid, 0);
`ifdef STG_WB_RETIRE_CNT_EN
      chk("cnt after rst", b0.ow_retire_cnt, 0);
`endif
      // Seventeen back-to-back entries at full throughput.
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         drive(1, 24'h60 + 24'(k), 1, 7, 0, 1);
         #1;
         if (k > 0) begin
            chk($sformatf("stream%0d valid", k), b0.ow_valid, 1);
            chk($sformatf("stream%0d pc", k), b0.ow_pc, 24'h60 + 24'(k - 1));
         end
         chk($sformatf("stream%0d ready", k), b0.ow_ready, 1);
      end
      @(negedge clk);
      drive(0, 24'h0, 0, 0, 0, 1);
      #1;
      chk("stream last pc", b0.ow_pc, 24'h70);
      @(negedge clk);
      #1;
      chk("stream empty", b0.ow_valid, 0);
`ifdef STG_WB_RETIRE_CNT_EN
      chk("cnt wrap", b0.ow_retire_cnt, 1);
`endif
      @(negedge clk);
      drive(1, 24'h80, 1, 7, 0, 0);
      @(negedge clk);
      drive(1, 24'h81, 1, 7, 1, 0);
      @(negedge clk);
      drive(0, 24'h0, 0, 0, 0, 0);
      #1;
      chk("flush2 valid", b0.ow_valid, 0);
      chk("flush2 ready", b0.ow_ready, 1);
`ifdef STG_WB_RETIRE_CNT_EN
      chk("cnt flush", b0.ow_retire_cnt, 1);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
